// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: feeds a parallel word MSB-first into an external
// 4x-run sequence detector, clears the detector before every word and
// counts the detector hits that belong to that word.
module seq_detect_ctrl #(
    parameter int WIDTH   = 16,
    parameter int DET_LAT = 1,
    parameter int CW      = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_valid,
    output logic             word_ready,
    output logic             det_bit,
    output logic             det_clear_n,
    input  logic             det_hit,
    output logic [CW-1:0]    hit_count,
    output logic             done,
    output logic             busy
);

    // cnt must reach WIDTH+DET_LAT-1 (end of the drain phase)
    localparam int CNTW = $clog2(WIDTH + DET_LAT + 1);

    localparam logic [CNTW-1:0] SHIFT_LAST = CNTW'(WIDTH - 1);
    localparam logic [CNTW-1:0] DRAIN_LAST = CNTW'(WIDTH + DET_LAT - 1);
    localparam logic [CNTW-1:0] WIN_FIRST  = CNTW'(DET_LAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  sh_q, sh_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]     hit_q, hit_d;
    logic              clr_n_q, clr_n_d;

    // State, shift register, counters and the detector clear line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            hit_q   <= '0;
            clr_n_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            clr_n_q <= clr_n_d;
        end
    end

    // Next-state logic, bit shifting and windowed hit counting
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        hit_d   = hit_q;
        clr_n_d = clr_n_q;

        case (state_q)
            S_IDLE: begin
                // The clear line keeps its value here, so after reset the
                // detector stays cleared until the first word arrives.
                if (word_valid) begin
                    sh_d    = word_in;
                    hit_d   = '0;
                    cnt_d   = '0;
                    clr_n_d = 1'b0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                clr_n_d = 1'b1;
                cnt_d   = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + CNTW'(1);
                if (cnt_q == SHIFT_LAST) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q + CNTW'(1);
                if (cnt_q == DRAIN_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Hits lag the driven bit by DET_LAT cycles; the window therefore
        // starts at cnt=DET_LAT and covers exactly WIDTH samples.
        if ((state_q == S_SHIFT || state_q == S_DRAIN) &&
            (cnt_q >= WIN_FIRST) && (cnt_q <= DRAIN_LAST) && det_hit) begin
            hit_d = hit_q + CW'(1);
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        word_ready  = (state_q == S_IDLE);
        busy        = (state_q == S_CLEAR) || (state_q == S_SHIFT) ||
                      (state_q == S_DRAIN);
        done        = (state_q == S_DONE);
        det_bit     = (state_q == S_SHIFT) && sh_q[WIDTH-1];
        det_clear_n = clr_n_q;
        hit_count   = hit_q;
    end

endmodule
